multi_ch_frame_avg: RTL and testbench

MULTI_CH_FRAME_AVG -- requirements
Module: multi_ch_frame_avg

---
 rtl/avg_pkg.sv | 26 ++
 rtl/seq_udiv.sv | 98 +++++++++
 rtl/multi_ch_frame_avg.sv | 204 ++++++++++++++++++++
 tb/tb_multi_ch_frame_avg.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// -----------------------------------------------------------------------------
// avg_pkg
//   Shared types and width helpers for multi_ch_frame_avg and seq_udiv.
//   Contents:
//     avg_state_e  - frame averager FSM states (IDLE, ACCUM, DIVIDE, OUTPUT)
//     ch_width()   - channel-index width: clog2(ch_n), never below 1 bit
//     cnt_width()  - width of a down-counter that must hold the value n
// -----------------------------------------------------------------------------
package avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_OUTPUT = 2'd3
  } avg_state_e;

  function automatic int ch_width(input int ch_n);
    return (ch_n > 1) ? $clog2(ch_n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// -----------------------------------------------------------------------------
// seq_udiv
//   Restoring unsigned divider, one quotient bit per clock.
//   The start cycle already produces the first quotient bit, so a DVD_W-bit
//   division finishes DVD_W edges after (and including) the start edge; o_done
//   pulses for one cycle once o_quotient is final.
//   Ports:
//     clk, rst_n           - clock, asynchronous active-low reset
//     i_start              - load operands and begin (ignored results if busy)
//     i_dividend[DVD_W]    - unsigned dividend
//     i_divisor[DVS_W]     - unsigned divisor, must be non-zero
//     o_busy               - division in progress
//     o_done               - one-cycle pulse, quotient valid from this cycle on
//     o_quotient[DVD_W]    - quotient, held until the next start
// -----------------------------------------------------------------------------
module seq_udiv
  import avg_pkg::*;
#(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);

  localparam int STEP_W = cnt_width(DVD_W);

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [DVD_W-1:0]  r_shift;
  logic [DVS_W-1:0]  r_rem;
  logic [DVS_W-1:0]  r_divisor;
  logic [STEP_W-1:0] r_steps;
  logic              r_busy;
  logic              r_done;

  logic [DVD_W-1:0]  w_shift_src;
  logic [DVS_W-1:0]  w_rem_src;
  logic [DVS_W-1:0]  w_dvs_src;
  logic [DVS_W:0]    w_trial;
  logic [DVS_W:0]    w_diff;
  logic              w_qbit;
  logic [DVS_W-1:0]  w_rem_nxt;
  logic [DVD_W-1:0]  w_shift_nxt;

  // One restoring step. On the start cycle it works on the fresh operands.
  // NOTE: every signal below is assigned on every path through the block,
  // so no latch can be inferred.
  always_comb begin
    w_shift_src = i_start ? i_dividend : r_shift;
    w_rem_src   = i_start ? '0 : r_rem;
    w_dvs_src   = i_start ? i_divisor : r_divisor;
    w_trial     = {w_rem_src, w_shift_src[DVD_W-1]};
    w_diff      = w_trial - {1'b0, w_dvs_src};
    w_qbit      = (w_trial >= {1'b0, w_dvs_src});
    // The partial remainder always stays below the divisor, so DVS_W bits hold it.
    w_rem_nxt   = w_qbit ? w_diff[DVS_W-1:0] : w_trial[DVS_W-1:0];
    w_shift_nxt = {w_shift_src[DVD_W-2:0], w_qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_steps   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_shift   <= w_shift_nxt;
        r_rem     <= w_rem_nxt;
        r_divisor <= w_dvs_src;
        r_steps   <= STEP_W'(DVD_W - 1);
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        r_shift <= w_shift_nxt;
        r_rem   <= w_rem_nxt;
        r_steps <= r_steps - STEP_W'(1);
        if (r_steps == STEP_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_shift;

endmodule

// File: rtl/multi_ch_frame_avg.sv
// -----------------------------------------------------------------------------
// multi_ch_frame_avg
//   Accumulates CH_N signed channels over a frame (sof .. eof) and emits the
//   per-channel mean with FRAC_W fractional bits, one channel per handshake.
//   A single seq_udiv is shared by all channels; the input stalls
//   (in_ready = 0) while results are being divided and delivered.
//   Frames longer than MAX_CNT samples keep only the first MAX_CNT samples
//   and report out_ovf.
//   Build option:
//     AVG_ROUND_EN - round the quotient magnitude half-up (one extra quotient
//                    bit, division takes one extra cycle); default truncates
//                    toward zero.
//   Ports:
//     clk, rst_n                 - clock, asynchronous active-low reset
//     in_data[CH_N*DATA_W]       - channel c at [c*DATA_W +: DATA_W]
//     in_valid/in_ready          - input handshake
//     in_sof, in_eof             - frame markers, qualified by the handshake
//     out_data[ACC_W+FRAC_W]     - signed mean, FRAC_W fractional bits
//     out_ch, out_cnt, out_ovf   - channel index, samples used, overflow flag
//     out_valid/out_ready        - output handshake
// -----------------------------------------------------------------------------
module multi_ch_frame_avg
  import avg_pkg::*;
#(
  parameter int DATA_W  = 54,
  parameter int CNT_W   = 10,
  parameter int CH_N    = 2,
  parameter int FRAC_W  = 15,
  parameter int MAX_CNT = 1001
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CH_N*DATA_W-1:0]           in_data,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic                             in_eof,
  output logic                             in_ready,
  output logic [DATA_W+CNT_W+FRAC_W-1:0]   out_data,
  output logic [ch_width(CH_N)-1:0]        out_ch,
  output logic [CNT_W-1:0]                 out_cnt,
  output logic                             out_ovf,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int ACC_W = DATA_W + CNT_W;
  localparam int OUT_W = ACC_W + FRAC_W;
`ifdef AVG_ROUND_EN
  localparam int QUO_W = OUT_W + 1;
`else
  localparam int QUO_W = OUT_W;
`endif
  localparam int              CH_W      = ch_width(CH_N);
  localparam logic [CNT_W-1:0] MAX_CNT_V = CNT_W'(MAX_CNT);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(CH_N - 1);

  avg_state_e       r_state;
  logic [ACC_W-1:0] r_acc [CH_N];
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [CH_W-1:0]  r_ch;
  logic             r_div_started;

  logic [ACC_W-1:0] w_sample [CH_N];
  logic [ACC_W-1:0] w_acc_sel;
  logic [ACC_W-1:0] w_acc_mag;
  logic             w_acc_neg;
  logic [QUO_W-1:0] w_dividend;
  logic [QUO_W-1:0] w_quo;
  logic [OUT_W-1:0] w_res_mag;
  logic [OUT_W-1:0] w_res;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
`ifdef AVG_ROUND_EN
  logic [QUO_W-1:0] w_quo_inc;
`endif

  // Sign-extend every channel sample to accumulator width.
  always_comb begin
    for (int c = 0; c < CH_N; c++) begin
      w_sample[c] = {{CNT_W{in_data[c*DATA_W+DATA_W-1]}}, in_data[c*DATA_W +: DATA_W]};
    end
  end

  // Divide on the magnitude, then restore the sign of the accumulator. The
  // most negative accumulator still has a representable ACC_W-bit magnitude.
  always_comb begin
    w_acc_sel  = r_acc[r_ch];
    w_acc_neg  = w_acc_sel[ACC_W-1];
    w_acc_mag  = w_acc_neg ? -w_acc_sel : w_acc_sel;
    w_dividend = QUO_W'(w_acc_mag) << (QUO_W - ACC_W);
`ifdef AVG_ROUND_EN
    // The quotient carries one extra fractional bit: adding one in that
    // position and dropping it rounds the magnitude half-up.
    w_quo_inc  = w_quo + QUO_W'(1);
    w_res_mag  = w_quo_inc[QUO_W-1:1];
`else
    w_res_mag  = w_quo;
`endif
    w_res      = w_acc_neg ? -w_res_mag : w_res_mag;
  end

  assign w_div_start = (r_state == ST_DIVIDE) && !r_div_started && !w_div_busy;

  seq_udiv #(
    .DVD_W (QUO_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (r_cnt),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  // Input is only taken while a frame can be opened or extended.
  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_ACCUM);

  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      // NOTE: the accumulator bank is small and must read as zero after
      // reset, so it is cleared like ordinary registers rather than left
      // uninitialised like a RAM.
      for (int c = 0; c < CH_N; c++) begin
        r_acc[c] <= '0;
      end
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_ch          <= '0;
      r_div_started <= 1'b0;
      out_data      <= '0;
      out_ch        <= '0;
      out_cnt       <= '0;
      out_ovf       <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (in_valid) begin
            if (in_sof) begin
              // A start of frame always (re)opens a frame, dropping any open one.
              for (int c = 0; c < CH_N; c++) begin
                r_acc[c] <= w_sample[c];
              end
              r_cnt   <= CNT_W'(1);
              r_ovf   <= 1'b0;
              r_ch    <= '0;
              r_state <= in_eof ? ST_DIVIDE : ST_ACCUM;
            end else if (r_state == ST_ACCUM) begin
              if (r_cnt == MAX_CNT_V) begin
                r_ovf <= 1'b1;
              end else begin
                for (int c = 0; c < CH_N; c++) begin
                  r_acc[c] <= r_acc[c] + w_sample[c];
                end
                r_cnt <= r_cnt + CNT_W'(1);
              end
              if (in_eof) begin
                r_ch    <= '0;
                r_state <= ST_DIVIDE;
              end
            end
          end
        end

        ST_DIVIDE: begin
          if (w_div_start) begin
            r_div_started <= 1'b1;
          end else if (r_div_started && w_div_done) begin
            r_div_started <= 1'b0;
            out_data      <= w_res;
            out_ch        <= r_ch;
            out_cnt       <= r_cnt;
            out_ovf       <= r_ovf;
            out_valid     <= 1'b1;
            r_state       <= ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_ch == LAST_CH) begin
              r_state <= ST_IDLE;
            end else begin
              r_ch    <= r_ch + CH_W'(1);
              r_state <= ST_DIVIDE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ch_frame_avg.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_frame_avg
//   Self-checking bench for multi_ch_frame_avg with DATA_W=16, CNT_W=4,
//   CH_N=2, FRAC_W=4, MAX_CNT=8. A frame-level model (sums, count, overflow)
//   predicts every output; a monitor compares on every cycle out_valid is
//   high and drives out_ready randomly. Directed frames pin the model with
//   hand-computed values. Honours AVG_ROUND_EN like the design.
// -----------------------------------------------------------------------------
module tb_multi_ch_frame_avg;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;
  localparam int CH_N    = 2;
  localparam int FRAC_W  = 4;
  localparam int MAX_CNT = 8;
  localparam int OUT_W   = DATA_W + CNT_W + FRAC_W;
`ifdef AVG_ROUND_EN
  localparam int     DIV_CYC = OUT_W + 1;
  localparam bit     ROUND   = 1'b1;
  localparam longint EXP3_0  = 27;
  localparam longint EXP3_1  = -27;
`else
  localparam int     DIV_CYC = OUT_W;
  localparam bit     ROUND   = 1'b0;
  localparam longint EXP3_0  = 26;
  localparam longint EXP3_1  = -26;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [CH_N*DATA_W-1:0] in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_sof = 1'b0;
  logic                   in_eof = 1'b0;
  logic                   in_ready;
  logic [OUT_W-1:0]       out_data;
  logic [0:0]             out_ch;
  logic [CNT_W-1:0]       out_cnt;
  logic                   out_ovf;
  logic                   out_valid;
  logic                   out_ready = 1'b0;

  multi_ch_frame_avg #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .CH_N    (CH_N),
    .FRAC_W  (FRAC_W),
    .MAX_CNT (MAX_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint data;
    int     ch;
    int     cnt;
    int     ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     n_total = 0;
  int     n_bad = 0;
  int     due = 0;
  bit     hold_ready = 1'b0;

  // Frame model state
  bit     in_frame = 1'b0;
  longint fsum[CH_N];
  int     fcnt = 0;
  int     fovf = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // Mean of a frame: sum * 2^FRAC_W / cnt on magnitudes, sign restored.
  function automatic longint mean(input longint s, input int n);
    longint mag;
    longint q;
    mag = ((s < 0) ? -s : s) * (longint'(1) << FRAC_W);
    if (ROUND) q = (2 * mag + n) / (2 * n);
    else       q = mag / n;
    return (s < 0) ? -q : q;
  endfunction

  function automatic int rnd_s();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Frame-level model of one accepted beat.
  task automatic model_accept(input int d0, input int d1, input bit sof, input bit eof);
    exp_t e;
    if (sof) begin
      fsum[0]  = d0;
      fsum[1]  = d1;
      fcnt     = 1;
      fovf     = 0;
      in_frame = 1'b1;
    end else if (in_frame) begin
      if (fcnt == MAX_CNT) begin
        fovf = 1;
      end else begin
        fsum[0] += d0;
        fsum[1] += d1;
        fcnt++;
      end
    end
    if (eof && in_frame) begin
      for (int c = 0; c < CH_N; c++) begin
        e.data = mean(fsum[c], fcnt);
        e.ch   = c;
        e.cnt  = fcnt;
        e.ovf  = fovf;
        exp_q.push_back(e);
      end
      in_frame = 1'b0;
      due = cyc + 2 + DIV_CYC;
    end
  endtask

  // Present a beat from a falling edge and hold it until it is accepted.
  task automatic send_beat(input int d0, input int d1, input bit sof, input bit eof);
    int n;
    int a;
    int b;
    n = 0;
    a = d0;
    b = d1;
    @(negedge clk);
    in_data  = {b[15:0], a[15:0]};
    in_valid = 1'b1;
    in_sof   = sof;
    in_eof   = eof;
    while (in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tmo("beat_accept");
      in_valid = 1'b0;
    end else begin
      model_accept(d0, d1, sof, eof);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
    end
  endtask

  // Wait for a given channel, check literal values, then wait for its handshake.
  task automatic expect_out(input int ch, input longint data, input int cnt,
                            input int ovf, input string tag);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_ch == ch) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tmo(tag);
    end else begin
      check({tag, "_data"}, $signed(out_data), data);
      check({tag, "_cnt"}, out_cnt, cnt);
      check({tag, "_ovf"}, out_ovf, ovf);
      n = 0;
      while (out_valid === 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) tmo({tag, "_handshake"});
    end
  endtask

  // Monitor: compare against the model on every valid cycle, drive out_ready.
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (!prev_v) check("latency", cyc, due);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          check("out_data", $signed(out_data), exp_q[0].data);
          check("out_ch", out_ch, exp_q[0].ch);
          check("out_cnt", out_cnt, exp_q[0].cnt);
          check("out_ovf", out_ovf, exp_q[0].ovf);
          check("in_ready_busy", in_ready, 0);
        end
        if (!hold_ready && exp_q.size() > 0 && $urandom_range(3) != 0) begin
          out_ready = 1'b1;
          due = cyc + 2 + DIV_CYC;
          void'(exp_q.pop_front());
        end else begin
          out_ready = 1'b0;
        end
      end else begin
        out_ready = 1'b0;
      end
      prev_v = (out_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Three-sample frame, fractional mean
    send_beat(1, -1, 1'b1, 1'b0);
    send_beat(2, -2, 1'b0, 1'b0);
    send_beat(2, -2, 1'b0, 1'b1);
    idle(1);
    expect_out(0, EXP3_0, 3, 0, "avg3_ch0");
    expect_out(1, EXP3_1, 3, 0, "avg3_ch1");

    // Overlong frame: only MAX_CNT samples kept, overflow flagged
    send_beat(1, 1, 1'b1, 1'b0);
    repeat (8) send_beat(1, 1, 1'b0, 1'b0);
    send_beat(1, 1, 1'b0, 1'b1);
    idle(1);
    expect_out(0, 16, 8, 1, "ovf_ch0");
    expect_out(1, 16, 8, 1, "ovf_ch1");

    // Single-beat frame clears the overflow flag
    send_beat(7, -3, 1'b1, 1'b1);
    idle(1);
    expect_out(0, 112, 1, 0, "one_ch0");
    expect_out(1, -48, 1, 0, "one_ch1");

    // Restart mid-frame
    send_beat(9, -9, 1'b1, 1'b0);
    send_beat(5, -5, 1'b0, 1'b0);
    send_beat(4, -4, 1'b1, 1'b0);
    send_beat(4, -4, 1'b0, 1'b1);
    idle(1);
    expect_out(0, 64, 2, 0, "restart_ch0");
    expect_out(1, -64, 2, 0, "restart_ch1");

    // Back-pressure: out_ready low for 20 cycles
    hold_ready = 1'b1;
    send_beat(10, -5, 1'b1, 1'b0);
    send_beat(1, 6, 1'b0, 1'b1);
    idle(1);
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) tmo("hold_wait");
    repeat (20) begin
      @(negedge clk);
      check("hold_data", $signed(out_data), 88);
      check("hold_ch", out_ch, 0);
      check("hold_in_ready", in_ready, 0);
    end
    hold_ready = 1'b0;
    expect_out(0, 88, 2, 0, "hold_ch0");
    expect_out(1, 8, 2, 0, "hold_ch1");

    // Reset during DIVIDE abandons the frame
    send_beat(20, 20, 1'b1, 1'b1);
    idle(6);
    rst_n = 1'b0;
    #1;
    check("rstdiv_out_valid", out_valid, 0);
    check("rstdiv_in_ready", in_ready, 1);
    check("rstdiv_out_data", out_data, 0);
    exp_q.delete();
    in_frame = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstdiv_in_ready_after", in_ready, 1);
    check("rstdiv_out_valid_after", out_valid, 0);
    idle(40);

    // Randomised frames with junk beats, gaps, restarts and overflow
    for (int f = 0; f < 25; f++) begin
      int nj;
      int len;
      nj  = $urandom_range(2);
      len = $urandom_range(11);
      for (int j = 0; j < nj; j++) begin
        send_beat(rnd_s(), rnd_s(), 1'b0, 1'($urandom_range(1)));
      end
      send_beat(rnd_s(), rnd_s(), 1'b1, len == 0);
      for (int b = 1; b <= len; b++) begin
        if ($urandom_range(2) == 0) idle($urandom_range(2, 1));
        send_beat(rnd_s(), rnd_s(), $urandom_range(9) == 0, b == len);
      end
      idle(1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) tmo("drain");
    idle(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
